uart_rgb_cmd: RTL and testbench
===============================

Name: uart_rgb_cmd

Overview:
- Command front-end between the `simpleuart` register interface and the `SB_RGBA_DRV` PWM inputs.
- Pops received bytes from the UART receive register and parses short ASCII commands that set per-channel 8-bit duty cycles.
- Drives three PWM outputs and answers each command with a one-byte status through the UART transmit register.

Parameters:
- PRESCALE, 47, PWM counter advances once every PRESCALE+1 clk cycles (12 MHz → 250 kHz tick; ~977 Hz PWM).
- TIMEOUT_CYCLES, 12000000, idle clk cycles allowed mid-command before silent abort (1 s at 12 MHz).

Ports:
- clk  input  1  system clock (12 MHz hw_clk)
- rst  input  1  asynchronous active-high reset
- reg_dat_do  input  32  simpleuart receive data; 32'hFFFFFFFF = no byte pending, else {24'b0, byte}
- reg_dat_re  output  1  one-cycle pop strobe to simpleuart
- reg_dat_we  output  1  transmit request to simpleuart
- reg_dat_di  output  32  transmit data {24'b0, byte}
- reg_dat_wait  input  1  simpleuart transmit stall
- pwm_red  output  1  to RGB0PWM
- pwm_green  output  1  to RGB1PWM
- pwm_blue  output  1  to RGB2PWM
- cmd_ok  output  1  one-cycle pulse when a command is applied
- cmd_err  output  1  one-cycle pulse on a parse error

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs 0 and all duties 0; state IDLE; prescaler, PWM counter and timeout counter 0.
- Byte fetch:
  - Fetch is permitted only in IDLE, HEX1, HEX2 and TERM, and only when reg_dat_do != 32'hFFFFFFFF.
  - On fetch: capture reg_dat_do[7:0] and assert reg_dat_re for exactly 1 cycle.
  - The following cycle is a blank cycle. Do not sample reg_dat_do during it, so the same byte is never read twice.
  - Bytes arriving during RESP stay buffered in simpleuart and are not popped.
- Command grammar: ch hex hex term.
  - ch: 'R', 'G', 'B' (uppercase only).
  - hex: 0-9, A-F, a-f.
  - term: CR (0x0D) or LF (0x0A).
  - Special command 'X' term sets all three duties to 0.
- FSM:
  - IDLE:
    - CR/LF: silently discarded, so CRLF line endings work.
    - 'R'/'G'/'B': latch the channel → HEX1.
    - 'X': → TERM with the clear-all flag set.
    - Any other byte: → RESP with '?'.
  - HEX1: valid hex → store the high nibble → HEX2; otherwise → RESP '?'.
  - HEX2: valid hex → store the low nibble → TERM; otherwise → RESP '?'.
  - TERM:
    - CR/LF: write the 8-bit value into the selected duty register (or clear all three for 'X'), pulse cmd_ok, → RESP 'K'.
    - Otherwise: → RESP '?'.
    - The duty register is updated in the same cycle cmd_ok pulses. Duties are never changed by incomplete or erroneous commands.
  - RESP:
    - Set reg_dat_di = {24'b0, resp} and assert reg_dat_we.
    - Hold both until a rising edge with reg_dat_we=1 && reg_dat_wait=0; deassert reg_dat_we next cycle → IDLE.
    - cmd_err pulses for 1 cycle on entry to RESP with '?'.
- Timeout:
  - The counter clears on every fetch and runs only in HEX1, HEX2 and TERM.
  - Reaching TIMEOUT_CYCLES → IDLE: no response, no pulse, duties unchanged.
- PWM:
  - The prescaler counts 0..PRESCALE; on wrap, the 8-bit counter increments (wraps 255→0).
  - pwm_x = (counter < duty_x), registered.
  - Duty 0 gives constant 0; duty 0xFF gives high 255 of 256 steps.
  - A new duty takes effect at the next counter compare (no glitch-free requirement across the period).
- Simultaneous events: a fetch and a timeout expiring in the same cycle resolve in favour of the fetch.
- Reset during RESP drops reg_dat_we immediately; the transmit may be truncated.

Test Plan:
- Reset: rst=1 → all outputs 0; release, reg_dat_do=FFFFFFFF for 100 cycles → no reg_dat_re, pwm_* stay 0.
- Feed "R80\n" one byte at a time (each held until popped) → exactly 4 reg_dat_re pulses; duty_red=0x80; cmd_ok once; transmit 'K' (0x4B); pwm_red high for 128 of every 256 PWM steps.
- Feed "g1f\r" then "GfF\r\n" → first returns '?' at 'g' (cmd_err), then 'K'; duty_green=0xFF; green high 255/256; trailing LF ignored.
- Feed "B4" then nothing for TIMEOUT_CYCLES (override to 100) → back in IDLE with no transmit and duty_blue unchanged; next "B40\n" → 'K', duty_blue=0x40.
- Hold reg_dat_wait=1 for 50 cycles during the 'K' response → reg_dat_we and reg_dat_di=0x4B stable throughout; a byte presented meanwhile is not popped until wait drops and the FSM returns to IDLE.
- With all duties nonzero send "X\n" → 'K'; all pwm_* 0 within one PWM period; assert rst mid-"R12" → duties 0, state IDLE, no response.

Source files
------------

// File: rtl/uart_rgb_cmd.sv
// ASCII command front-end for simpleuart: parses "R/G/B hex hex CR|LF" and "X CR|LF",
// drives three PWM duty registers and answers each command with 'K' or '?'.
module uart_rgb_cmd #(
    parameter int PRESCALE       = 47,
    parameter int TIMEOUT_CYCLES = 12000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] reg_dat_do,
    output logic        reg_dat_re,
    output logic        reg_dat_we,
    output logic [31:0] reg_dat_di,
    input  logic        reg_dat_wait,
    output logic        pwm_red,
    output logic        pwm_green,
    output logic        pwm_blue,
    output logic        cmd_ok,
    output logic        cmd_err
);
    localparam int PW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_HEX1, S_HEX2, S_TERM, S_RESP} state_t;
    state_t state, state_nx;

    logic [7:0]    rx_byte;
    logic [1:0]    chan, chan_sel;
    logic          clr_all;
    logic [3:0]    hi_nib, lo_nib, nib;
    logic [7:0]    duty_red, duty_green, duty_blue;
    logic [TW-1:0] tmo_cnt;
    logic [PW-1:0] pre_cnt;
    logic [7:0]    pwm_cnt;

    logic fetch, is_hex, is_term, tmo_hit, counting;
    logic latch_chan, set_clr, latch_hi, latch_lo, apply, go_resp, ok_nx, err_nx;
    logic [7:0] resp_char;

    // rx_byte is only meaningful in the cycle reg_dat_re is high; that cycle is also
    // the blank cycle, so fetch is blocked while the pop is in flight.
    always_comb begin
        fetch    = (state != S_RESP) && !reg_dat_re && (reg_dat_do != '1);
        counting = (state == S_HEX1) || (state == S_HEX2) || (state == S_TERM);
        tmo_hit  = counting && !fetch && (tmo_cnt == TMO_MAX);
        is_term  = (rx_byte == 8'h0D) || (rx_byte == 8'h0A);
        is_hex   = 1'b1;
        nib      = '0;
        if (rx_byte >= 8'h30 && rx_byte <= 8'h39)
            nib = rx_byte[3:0];
        else if ((rx_byte >= 8'h41 && rx_byte <= 8'h46) || (rx_byte >= 8'h61 && rx_byte <= 8'h66))
            nib = rx_byte[3:0] + 4'd9;
        else
            is_hex = 1'b0;

        chan_sel = 2'd0;
        if (rx_byte == 8'h47) chan_sel = 2'd1;
        if (rx_byte == 8'h42) chan_sel = 2'd2;

        state_nx   = state;
        latch_chan = 1'b0;
        set_clr    = 1'b0;
        latch_hi   = 1'b0;
        latch_lo   = 1'b0;
        apply      = 1'b0;
        go_resp    = 1'b0;
        ok_nx      = 1'b0;
        err_nx     = 1'b0;
        resp_char  = 8'h3F;

        case (state)
            S_IDLE: if (reg_dat_re) begin
                if (is_term) begin
                    state_nx = S_IDLE;
                end else if (rx_byte == 8'h52 || rx_byte == 8'h47 || rx_byte == 8'h42) begin
                    latch_chan = 1'b1;
                    state_nx   = S_HEX1;
                end else if (rx_byte == 8'h58) begin
                    set_clr  = 1'b1;
                    state_nx = S_TERM;
                end else begin
                    err_nx = 1'b1;
                end
            end
            S_HEX1: if (reg_dat_re) begin
                if (is_hex) begin
                    latch_hi = 1'b1;
                    state_nx = S_HEX2;
                end else begin
                    err_nx = 1'b1;
                end
            end else if (tmo_hit) begin
                state_nx = S_IDLE;
            end
            S_HEX2: if (reg_dat_re) begin
                if (is_hex) begin
                    latch_lo = 1'b1;
                    state_nx = S_TERM;
                end else begin
                    err_nx = 1'b1;
                end
            end else if (tmo_hit) begin
                state_nx = S_IDLE;
            end
            S_TERM: if (reg_dat_re) begin
                if (is_term) begin
                    apply     = 1'b1;
                    ok_nx     = 1'b1;
                    go_resp   = 1'b1;
                    resp_char = 8'h4B;
                    state_nx  = S_RESP;
                end else begin
                    err_nx = 1'b1;
                end
            end else if (tmo_hit) begin
                state_nx = S_IDLE;
            end
            S_RESP: if (reg_dat_we && !reg_dat_wait) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        if (err_nx) begin
            go_resp  = 1'b1;
            state_nx = S_RESP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            reg_dat_re <= 1'b0;
            reg_dat_we <= 1'b0;
            reg_dat_di <= '0;
            rx_byte    <= '0;
            chan       <= '0;
            clr_all    <= 1'b0;
            hi_nib     <= '0;
            lo_nib     <= '0;
            duty_red   <= '0;
            duty_green <= '0;
            duty_blue  <= '0;
            tmo_cnt    <= '0;
            cmd_ok     <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            state      <= state_nx;
            reg_dat_re <= fetch;
            cmd_ok     <= ok_nx;
            cmd_err    <= err_nx;
            if (fetch) rx_byte <= reg_dat_do[7:0];
            if (fetch || !counting) tmo_cnt <= '0;
            else                    tmo_cnt <= tmo_cnt + 1'b1;
            if (latch_chan) begin
                chan    <= chan_sel;
                clr_all <= 1'b0;
            end
            if (set_clr)  clr_all <= 1'b1;
            if (latch_hi) hi_nib  <= nib;
            if (latch_lo) lo_nib  <= nib;
            if (apply) begin
                if (clr_all) begin
                    duty_red   <= '0;
                    duty_green <= '0;
                    duty_blue  <= '0;
                end else begin
                    case (chan)
                        2'd0:    duty_red   <= {hi_nib, lo_nib};
                        2'd1:    duty_green <= {hi_nib, lo_nib};
                        default: duty_blue  <= {hi_nib, lo_nib};
                    endcase
                end
            end
            if (go_resp) begin
                reg_dat_we <= 1'b1;
                reg_dat_di <= {24'b0, resp_char};
            end else if (state == S_RESP && reg_dat_we && !reg_dat_wait) begin
                reg_dat_we <= 1'b0;
                reg_dat_di <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt   <= '0;
            pwm_cnt   <= '0;
            pwm_red   <= 1'b0;
            pwm_green <= 1'b0;
            pwm_blue  <= 1'b0;
        end else begin
            if (pre_cnt == PRE_MAX) begin
                pre_cnt <= '0;
                pwm_cnt <= pwm_cnt + 1'b1;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
            pwm_red   <= (pwm_cnt < duty_red);
            pwm_green <= (pwm_cnt < duty_green);
            pwm_blue  <= (pwm_cnt < duty_blue);
        end
    end
endmodule

// File: tb/tb_uart_rgb_cmd.sv
// Bench for uart_rgb_cmd: simpleuart receive queue model, scoreboard of expected
// response bytes, and PWM duty measurement over full 256-step periods.
module tb_uart_rgb_cmd;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] reg_dat_do = '1;
    logic        reg_dat_re, reg_dat_we;
    logic [31:0] reg_dat_di;
    logic        reg_dat_wait = 1'b0;
    logic        pwm_red, pwm_green, pwm_blue, cmd_ok, cmd_err;

    int n_checks = 0, n_fail = 0;
    int n_pops = 0, n_pop_empty = 0, n_ok = 0, n_err = 0, n_tx = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    uart_rgb_cmd #(.PRESCALE(0), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst),
        .reg_dat_do(reg_dat_do), .reg_dat_re(reg_dat_re),
        .reg_dat_we(reg_dat_we), .reg_dat_di(reg_dat_di), .reg_dat_wait(reg_dat_wait),
        .pwm_red(pwm_red), .pwm_green(pwm_green), .pwm_blue(pwm_blue),
        .cmd_ok(cmd_ok), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    // simpleuart receive side: head of queue is visible until popped
    always @(posedge clk) begin
        if (reg_dat_re) begin
            if (rx_q.size() > 0) begin
                void'(rx_q.pop_front());
                n_pops++;
            end else begin
                n_pop_empty++;
            end
        end
        reg_dat_do <= (rx_q.size() > 0) ? {24'b0, rx_q[0]} : '1;
    end

    // transmit scoreboard and pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_ok)  n_ok++;
            if (cmd_err) n_err++;
            if (reg_dat_we && !reg_dat_wait) begin
                logic [7:0] e;
                n_tx++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL tx_unexpected: got %02h, required no transmit", reg_dat_di[7:0]);
                end else begin
                    e = exp_q.pop_front();
                    if (reg_dat_di !== {24'b0, e}) begin
                        n_fail++;
                        $display("FAIL tx_byte: got %08h, required %08h", reg_dat_di, {24'b0, e});
                    end
                end
            end
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input string s, input string rsp);
        for (int unsigned i = 0; i < s.len(); i++) rx_q.push_back(s[i]);
        for (int unsigned i = 0; i < rsp.len(); i++) exp_q.push_back(rsp[i]);
    endtask

    task automatic wait_done(input string name);
        int unsigned n = 0;
        while (!(rx_q.size() == 0 && exp_q.size() == 0 && !reg_dat_we && !reg_dat_re) && n < 3000) begin
            tick(1);
            n++;
        end
        n_checks++;
        if (n >= 3000) begin
            n_fail++;
            $display("FAIL %s_done: rx left %0d, tx left %0d, required 0/0", name, rx_q.size(), exp_q.size());
        end
        tick(4);
    endtask

    task automatic measure(output int r, output int g, output int b);
        r = 0; g = 0; b = 0;
        for (int unsigned i = 0; i < 256; i++) begin
            @(negedge clk);
            r += int'(pwm_red);
            g += int'(pwm_green);
            b += int'(pwm_blue);
        end
        tick(1);
    endtask

    task automatic test_reset();
        int r, g, b;
        rst = 1'b1;
        tick(3);
        n_checks++;
        if ({reg_dat_re, reg_dat_we, reg_dat_di, pwm_red, pwm_green, pwm_blue, cmd_ok, cmd_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: re=%b we=%b di=%08h pwm=%b%b%b ok=%b err=%b, required all 0",
                     reg_dat_re, reg_dat_we, reg_dat_di, pwm_red, pwm_green, pwm_blue, cmd_ok, cmd_err);
        end
        rst = 1'b0;
        tick(100);
        measure(r, g, b);
        n_checks++;
        if (n_pops + n_pop_empty != 0) begin
            n_fail++;
            $display("FAIL reset_no_pop: got %0d pops, required 0", n_pops + n_pop_empty);
        end
        n_checks++;
        if (r + g + b != 0) begin
            n_fail++;
            $display("FAIL reset_pwm: got %0d/%0d/%0d high, required 0/0/0", r, g, b);
        end
    endtask

    task automatic test_red();
        int r, g, b;
        int p0 = n_pops, ok0 = n_ok;
        send("R80\n", "K");
        wait_done("red");
        n_checks++;
        if (n_pops - p0 != 4) begin
            n_fail++;
            $display("FAIL red_pops: got %0d, required 4", n_pops - p0);
        end
        n_checks++;
        if (n_ok - ok0 != 1) begin
            n_fail++;
            $display("FAIL red_ok: got %0d pulses, required 1", n_ok - ok0);
        end
        measure(r, g, b);
        n_checks++;
        if (r != 128 || g != 0 || b != 0) begin
            n_fail++;
            $display("FAIL red_pwm: got %0d/%0d/%0d high, required 128/0/0", r, g, b);
        end
    endtask

    task automatic test_green_errors();
        int r, g, b;
        int p0 = n_pops, ok0 = n_ok, e0 = n_err;
        send("g1f\r", "???");
        send("GfF\r\n", "K");
        wait_done("green");
        n_checks++;
        if (n_err - e0 != 3 || n_ok - ok0 != 1) begin
            n_fail++;
            $display("FAIL green_pulses: got err=%0d ok=%0d, required err=3 ok=1", n_err - e0, n_ok - ok0);
        end
        n_checks++;
        if (n_pops - p0 != 9) begin
            n_fail++;
            $display("FAIL green_pops: got %0d, required 9", n_pops - p0);
        end
        measure(r, g, b);
        n_checks++;
        if (r != 128 || g != 255 || b != 0) begin
            n_fail++;
            $display("FAIL green_pwm: got %0d/%0d/%0d high, required 128/255/0", r, g, b);
        end
    endtask

    task automatic test_timeout();
        int r, g, b;
        int p0 = n_pops, t0 = n_tx, ok0 = n_ok, e0 = n_err;
        int unsigned n = 0;
        send("B4", "");
        while (n_pops - p0 < 2 && n < 100) begin
            tick(1);
            n++;
        end
        tick(150);
        n_checks++;
        if (n_tx != t0 || n_ok != ok0 || n_err != e0 || n_pops - p0 != 2) begin
            n_fail++;
            $display("FAIL timeout_silent: got tx=%0d ok=%0d err=%0d pops=%0d, required 0/0/0/2",
                     n_tx - t0, n_ok - ok0, n_err - e0, n_pops - p0);
        end
        measure(r, g, b);
        n_checks++;
        if (b != 0) begin
            n_fail++;
            $display("FAIL timeout_blue: got %0d high, required 0", b);
        end
        send("B40\n", "K");
        wait_done("blue");
        measure(r, g, b);
        n_checks++;
        if (r != 128 || g != 255 || b != 64) begin
            n_fail++;
            $display("FAIL blue_pwm: got %0d/%0d/%0d high, required 128/255/64", r, g, b);
        end
    endtask

    task automatic test_tx_wait();
        int r, g, b, p1;
        int unsigned n = 0;
        logic bad = 1'b0;
        reg_dat_wait = 1'b1;
        send("G10\n", "K");
        while (!reg_dat_we && n < 100) begin
            tick(1);
            n++;
        end
        p1 = n_pops;
        for (int unsigned i = 0; i < 50; i++) begin
            if (i == 10) rx_q.push_back(8'h0A);
            @(negedge clk);
            if (reg_dat_we !== 1'b1 || reg_dat_di !== 32'h0000_004B) bad = 1'b1;
            tick(1);
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL wait_hold: we/di changed under stall (now we=%b di=%08h), required 1/0000004b",
                     reg_dat_we, reg_dat_di);
        end
        n_checks++;
        if (n_pops != p1) begin
            n_fail++;
            $display("FAIL wait_no_pop: got %0d pops during stall, required 0", n_pops - p1);
        end
        reg_dat_wait = 1'b0;
        wait_done("wait");
        n_checks++;
        if (n_pops - p1 != 1) begin
            n_fail++;
            $display("FAIL wait_late_pop: got %0d pops after stall, required 1", n_pops - p1);
        end
        measure(r, g, b);
        n_checks++;
        if (g != 16) begin
            n_fail++;
            $display("FAIL wait_green: got %0d high, required 16", g);
        end
    endtask

    task automatic test_clear_and_reset();
        int r, g, b, t0, p0;
        int unsigned n = 0;
        send("X\n", "K");
        wait_done("clear");
        measure(r, g, b);
        n_checks++;
        if (r + g + b != 0) begin
            n_fail++;
            $display("FAIL clear_pwm: got %0d/%0d/%0d high, required 0/0/0", r, g, b);
        end
        send("R80\n", "K");
        wait_done("red2");
        p0 = n_pops;
        t0 = n_tx;
        send("R12", "");
        while (n_pops - p0 < 3 && n < 100) begin
            tick(1);
            n++;
        end
        tick(2);
        rst = 1'b1;
        rx_q.delete();
        tick(2);
        n_checks++;
        if ({reg_dat_re, reg_dat_we, reg_dat_di, pwm_red, pwm_green, pwm_blue, cmd_ok, cmd_err} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: re=%b we=%b di=%08h pwm=%b%b%b, required all 0",
                     reg_dat_re, reg_dat_we, reg_dat_di, pwm_red, pwm_green, pwm_blue);
        end
        rst = 1'b0;
        tick(20);
        measure(r, g, b);
        n_checks++;
        if (r + g + b != 0 || n_tx != t0) begin
            n_fail++;
            $display("FAIL midreset_state: got pwm %0d/%0d/%0d tx=%0d, required 0/0/0 tx=0",
                     r, g, b, n_tx - t0);
        end
        send("R12\n", "K");
        wait_done("post_reset");
        measure(r, g, b);
        n_checks++;
        if (r != 18) begin
            n_fail++;
            $display("FAIL post_reset_red: got %0d high, required 18", r);
        end
    endtask

    initial begin
        test_reset();
        test_red();
        test_green_errors();
        test_timeout();
        test_tx_wait();
        test_clear_and_reset();
        n_checks++;
        if (exp_q.size() != 0 || n_pop_empty != 0) begin
            n_fail++;
            $display("FAIL final: got %0d pending responses, %0d empty pops, required 0/0",
                     exp_q.size(), n_pop_empty);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
